// File: rtl/mp3_pkg.sv
// Shared definitions for the album-art path: loader state encoding,
// picture geometry and the 12-bit RGB pixel layout also used by the display reader.
package mp3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_DONE,
        ST_ERR
    } art_state_t;

    localparam int         ART_W     = 50;
    localparam int         ART_H     = 50;
    localparam int         ART_PIX   = ART_W * ART_H;
    localparam logic [7:0] ART_MAGIC = 8'hA5;

    // Pixel field positions inside the 16-bit RAM word.
    localparam int PIX_R_LSB   = 0;
    localparam int PIX_G_LSB   = 4;
    localparam int PIX_B_LSB   = 8;
    localparam int PIX_FIELD_W = 4;

    // Low byte carries G:R, the high byte's low nibble carries B.
    function automatic logic [15:0] art_pack(input logic [7:0] lo, input logic [7:0] hi);
        logic [15:0] w;
        w = 16'h0000;
        w[PIX_R_LSB +: PIX_FIELD_W] = lo[3:0];
        w[PIX_G_LSB +: PIX_FIELD_W] = lo[7:4];
        w[PIX_B_LSB +: PIX_FIELD_W] = hi[3:0];
        return w;
    endfunction

endpackage

// File: rtl/cover_art_loader_idle_timeout.sv
// Reloadable idle down-counter: flags expiry once TIMEOUT enabled cycles
// have elapsed since the last load without another load.
module idle_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int                CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Reload on demand, otherwise count down while enabled and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = i_en & (r_cnt == '0);

endmodule

// File: rtl/cover_art_loader.sv
// Album-art writer: checks a header byte, packs byte pairs into 12-bit RGB
// words and writes them in row-major order into port A of the picture RAM.
module cover_art_loader
    import mp3_pkg::*;
#(
    parameter int         PIX_W   = ART_W,
    parameter int         PIX_H   = ART_H,
    parameter int         ADDR_W  = 15,
    parameter logic [7:0] MAGIC   = ART_MAGIC,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_wea,
    output logic [ADDR_W-1:0] o_addra,
    output logic [15:0]       o_dina,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_pix_cnt
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIX_W * PIX_H - 1);

    art_state_t        r_state;
    art_state_t        w_state_next;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [15:0]       r_dina;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [7:0]        r_lo;

    logic w_busy;
    logic w_ready;
    logic w_hs;
    logic w_last;
    logic w_expired;

    assign w_busy  = (r_state == ST_HDR) || (r_state == ST_LO) || (r_state == ST_HI);
    assign w_ready = w_busy & ~i_start;
    assign w_hs    = i_valid & w_ready;
    assign w_last  = (r_pix_cnt == LAST_IDX);

    // Idle time only accrues in the loading states on cycles without a byte.
    idle_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (i_start | w_hs),
        .i_en      (w_busy & ~w_hs & ~i_start),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a start pulse overrides everything, including a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = ST_HDR;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_hs)           w_state_next = (i_data == MAGIC) ? ST_LO : ST_ERR;
                    else if (w_expired) w_state_next = ST_ERR;
                end
                ST_LO: begin
                    if (w_hs)           w_state_next = ST_HI;
                    else if (w_expired) w_state_next = ST_ERR;
                end
                ST_HI: begin
                    if (w_hs)           w_state_next = w_last ? ST_DONE : ST_LO;
                    else if (w_expired) w_state_next = ST_ERR;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Pixel datapath: latch the low byte, then register one RAM write per completed pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wea     <= 1'b0;
            r_addra   <= '0;
            r_dina    <= '0;
            r_pix_cnt <= '0;
            r_lo      <= '0;
        end else begin
            r_wea <= 1'b0;
            if (i_start) begin
                r_pix_cnt <= '0;
            end else if ((r_state == ST_HI) && w_hs) begin
                r_wea     <= 1'b1;
                r_addra   <= r_pix_cnt;
                r_dina    <= art_pack(r_lo, i_data);
                r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
            if ((r_state == ST_LO) && w_hs) begin
                r_lo <= i_data;
            end
        end
    end

    assign o_ready   = w_ready;
    assign o_wea     = r_wea;
    assign o_addra   = r_addra;
    assign o_dina    = r_dina;
    assign o_busy    = w_busy;
    assign o_done    = (r_state == ST_DONE);
    assign o_err     = (r_state == ST_ERR);
    assign o_pix_cnt = r_pix_cnt;

endmodule

// File: tb/tb_cover_art_loader.sv
// Randomised bench for cover_art_loader with a behavioural model of the load protocol.
module tb_cover_art_loader;
    localparam int TO     = 16;
    localparam int ADDR_W = 15;
    localparam int NPIX   = 2500;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [7:0]        i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_wea;
    logic [ADDR_W-1:0] o_addra;
    logic [15:0]       o_dina;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [ADDR_W-1:0] o_pix_cnt;

    cover_art_loader #(
        .PIX_W(50), .PIX_H(50), .ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_wea(o_wea), .o_addra(o_addra), .o_dina(o_dina),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_pix_cnt(o_pix_cnt)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 header, 2 low byte, 3 high byte, 4 done, 5 error.
    int m_phase, m_cnt, m_idle, m_lo, m_addr, m_din;
    bit m_wea;

    int n_cmp, n_fail;
    int n_wea, max_addr, first_addr, din_at7;
    byte unsigned q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_phase >= 1) && (m_phase <= 3);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_idle = 0; m_lo = 0; m_wea = 0; m_addr = 0; m_din = 0;
    endtask

    task automatic stats_reset();
        n_wea = 0; max_addr = 0; first_addr = -1; din_at7 = -1;
    endtask

    task automatic model_update(input bit s, input bit hs, input logic [7:0] d);
        m_wea = 0;
        if (s) begin
            m_phase = 1; m_cnt = 0; m_idle = 0;
        end else if (m_busy()) begin
            if (hs) begin
                m_idle = 0;
                case (m_phase)
                    1: m_phase = (d == 8'hA5) ? 2 : 5;
                    2: begin m_lo = int'(d); m_phase = 3; end
                    default: begin
                        m_wea   = 1;
                        m_addr  = m_cnt;
                        m_din   = (int'(d) % 16) * 256 + m_lo;
                        m_cnt++;
                        m_phase = (m_cnt == NPIX) ? 4 : 2;
                    end
                endcase
            end else begin
                m_idle++;
                if (m_idle == TO) m_phase = 5;
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy", o_busy, m_busy());
        chk("done", o_done, m_phase == 4);
        chk("err", o_err, m_phase == 5);
        chk("pix_cnt", o_pix_cnt, m_cnt);
        chk("wea", o_wea, m_wea);
        if (m_wea) begin
            chk("addra", o_addra, m_addr);
            chk("dina", o_dina, m_din);
        end
        if (o_wea) begin
            n_wea++;
            if (first_addr < 0) first_addr = int'(o_addra);
            if (int'(o_addra) > max_addr) max_addr = int'(o_addra);
            if (o_addra == 7) din_at7 = int'(o_dina);
        end
    endtask

    task automatic step(input bit s, input bit v, input logic [7:0] d, output bit hs);
        @(negedge clk);
        i_start = s; i_valid = v; i_data = d;
        #1;
        chk("ready", o_ready, m_busy() && !s);
        hs = v && m_busy() && !s;
        @(posedge clk);
        model_update(s, hs, d);
        #1;
        check_outputs();
    endtask

    task automatic start_pulse();
        bit hs;
        step(1'b1, 1'b1, 8'(($urandom)), hs);
    endtask

    task automatic push_image(input int npix);
        q.push_back(8'hA5);
        for (int i = 0; i < npix; i++) begin
            if (i == 7) begin
                q.push_back(8'h34); q.push_back(8'hF2);
            end else begin
                q.push_back(8'($urandom)); q.push_back(8'($urandom));
            end
        end
    endtask

    // Feed queued bytes; optionally restart right after the high-byte handshake of pixel trick_at.
    task automatic feed(input int gap_pct, input int max_cycles, input int trick_at);
        bit hs, v, tricked;
        int cyc;
        tricked = 0;
        cyc = 0;
        while (q.size() > 0 && cyc < max_cycles) begin
            if (!tricked && trick_at >= 0 && m_phase == 3 && m_cnt == trick_at) begin
                step(1'b0, 1'b1, q[0], hs);
                void'(q.pop_front());
                chk("pending_wea", o_wea, 1);
                step(1'b1, 1'b1, 8'hEE, hs);
                chk("start_byte_taken", hs, 0);
                chk("start_clears_cnt", o_pix_cnt, 0);
                tricked = 1;
                q.delete();
                push_image(NPIX);
            end else begin
                v = ($urandom_range(99) >= gap_pct);
                step(1'b0, v, q[0], hs);
                if (hs) void'(q.pop_front());
            end
            cyc++;
        end
        chk("feed_drained", q.size(), 0);
    endtask

    task automatic check_reset_zero();
        chk("rst_ready", o_ready, 0);
        chk("rst_wea", o_wea, 0);
        chk("rst_addra", o_addra, 0);
        chk("rst_dina", o_dina, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_pix_cnt", o_pix_cnt, 0);
    endtask

    initial begin
        bit hs;
        int saved;
        n_cmp = 0; n_fail = 0;
        stats_reset();
        model_reset();
        rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_data = 8'h00;
        #3;
        check_reset_zero();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle: bytes offered but never accepted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hA5, hs);

        // Full image with valid held high.
        stats_reset();
        start_pulse();
        push_image(NPIX);
        feed(0, 6000, -1);
        chk("full_wea_count", n_wea, 2500);
        chk("full_first_addr", first_addr, 0);
        chk("full_max_addr", max_addr, 2499);
        chk("pixel_34_F2", din_at7, 16'h0234);
        chk("full_done", o_done, 1);
        chk("full_pix_cnt", o_pix_cnt, 2500);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h55, hs);
        chk("after_done_wea_count", n_wea, 2500);

        // Bad header.
        start_pulse();
        saved = n_wea;
        step(1'b0, 1'b1, 8'h3C, hs);
        chk("bad_hdr_err", o_err, 1);
        chk("bad_hdr_ready", o_ready, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hA5, hs);
        chk("bad_hdr_no_wea", n_wea, saved);

        // Restart after 100 pixels, then a full stream.
        start_pulse();
        push_image(100);
        feed(0, 1000, -1);
        chk("partial_pix_cnt", o_pix_cnt, 100);
        start_pulse();
        stats_reset();
        push_image(NPIX);
        feed(0, 6000, -1);
        chk("restart_first_addr", first_addr, 0);
        chk("restart_pix_cnt", o_pix_cnt, 2500);

        // Stall in the low-byte state.
        start_pulse();
        q.push_back(8'hA5); q.push_back(8'h11); q.push_back(8'h22);
        feed(0, 20, -1);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 8'h00, hs);
        chk("stall_no_err_yet", o_err, 0);
        step(1'b0, 1'b0, 8'h00, hs);
        chk("stall_err", o_err, 1);
        chk("stall_busy", o_busy, 0);

        // Random gaps with a restart on a pending write.
        stats_reset();
        start_pulse();
        push_image(NPIX);
        feed(30, 30000, 600);
        chk("gap_addr_bound", max_addr <= 2499, 1);
        chk("gap_done", o_done, 1);

        // Asynchronous reset in the middle of a load.
        start_pulse();
        push_image(NPIX);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, q[0], hs);
            if (hs) void'(q.pop_front());
        end
        for (int i = 0; i < 4 && !m_wea; i++) begin
            step(1'b0, 1'b1, q[0], hs);
            if (hs) void'(q.pop_front());
        end
        chk("mid_wea_before_reset", o_wea, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_zero();
        model_reset();
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hA5, hs);
        start_pulse();
        push_image(5);
        feed(10, 100, -1);
        chk("post_reset_pix_cnt", o_pix_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
